// File: rtl/switch_input.sv
// Four-switch debounced input block with a small register bus.
// Synchronize, debounce, latch edge events, raise a level irq.

module switch_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic deb,
  output logic rise,
  output logic fall
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          deb_q;
  logic          deb_d;

  always_comb begin
    cnt_d = '0;
    deb_d = deb_q;
    if (din != deb_q) begin
      if (cnt_q == CMAX) begin
        deb_d = ~deb_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
      deb_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      deb_q <= deb_d;
    end
  end

  assign deb  = deb_q;
  // Event strobes land on the same edge the debounced bit flips.
  assign rise = deb_d & ~deb_q;
  assign fall = ~deb_d & deb_q;

endmodule

module switch_input #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  switch,
  input  logic        rd_en,
  input  logic        wr_en,
  input  logic [3:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        rvalid,
  output logic        irq
);

  localparam logic [3:0] A_STATE = 4'h0;
  localparam logic [3:0] A_EDGE  = 4'h4;
  localparam logic [3:0] A_IEN   = 4'h8;

  logic [3:0]  sync1;
  logic [3:0]  sync2;
  logic [3:0]  deb;
  logic [3:0]  rise;
  logic [3:0]  fall;
  logic [7:0]  edge_q;
  logic [7:0]  ien_q;
  logic [7:0]  edge_set;
  logic [7:0]  edge_clr;
  logic        sel_state;
  logic        sel_edge;
  logic        sel_ien;
  logic [31:0] rd_mux;
  logic        unused_wdata;

  assign unused_wdata = ^wdata[31:8];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= switch;
      sync2 <= sync1;
    end
  end

  for (genvar i = 0; i < 4; i++) begin : g_deb
    switch_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk  (clk),
      .reset(reset),
      .din  (sync2[i]),
      .deb  (deb[i]),
      .rise (rise[i]),
      .fall (fall[i])
    );
  end

  assign sel_state = (addr == A_STATE);
  assign sel_edge  = (addr == A_EDGE);
  assign sel_ien   = (addr == A_IEN);

  assign edge_set = {fall, rise};
  assign edge_clr = (wr_en && sel_edge) ? wdata[7:0] : 8'h00;

  always_comb begin
    rd_mux = '0;
    unique case (1'b1)
      sel_state: rd_mux = {28'h0, deb};
      sel_edge:  rd_mux = {24'h0, edge_q};
      sel_ien:   rd_mux = {24'h0, ien_q};
      default:   rd_mux = '0;
    endcase
  end

  // Set term is OR'd after the clear so a coincident event survives W1C.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      edge_q <= '0;
      ien_q  <= '0;
      irq    <= 1'b0;
    end else begin
      edge_q <= (edge_q & ~edge_clr) | edge_set;
      if (wr_en && sel_ien) begin
        ien_q <= wdata[7:0];
      end
      irq <= |(edge_q & ien_q);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata  <= '0;
      rvalid <= 1'b0;
    end else begin
      rvalid <= rd_en;
      if (rd_en) begin
        rdata <= rd_mux;
      end
    end
  end

endmodule

// File: tb/tb_switch_input.sv
// Directed bench for switch_input at DEBOUNCE_CYCLES=4.
// Inputs change 1ns after rising edges; outputs sampled there too.

module tb_switch_input;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  switch;
  logic        rd_en;
  logic        wr_en;
  logic [3:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        rvalid;
  logic        irq;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  switch_input #(
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .switch(switch),
    .rd_en (rd_en),
    .wr_en (wr_en),
    .addr  (addr),
    .wdata (wdata),
    .rdata (rdata),
    .rvalid(rvalid),
    .irq   (irq)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_wr(input logic [3:0] a,
                        input logic [31:0] d);
    wr_en = 1'b1;
    addr  = a;
    wdata = d;
    tick();
    wr_en = 1'b0;
    wdata = '0;
  endtask

  task automatic rd_chk(input string tag,
                        input logic [3:0] a,
                        input logic [31:0] exp);
    rd_en = 1'b1;
    addr  = a;
    tick();
    rd_en = 1'b0;
    chk({tag, "_rv"}, {31'h0, rvalid}, 32'h1);
    chk(tag, rdata, exp);
  endtask

  initial begin
    reset  = 1'b0;
    switch = '0;
    rd_en  = 1'b0;
    wr_en  = 1'b0;
    addr   = '0;
    wdata  = '0;
    repeat (3) tick();
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_rvalid", {31'h0, rvalid}, 32'h0);
    chk("rst_irq", {31'h0, irq}, 32'h0);
    reset = 1'b1;
    repeat (2) tick();

    // clean rise on bits 0 and 2, observed through back-to-back reads
    switch = 4'b0101;
    rd_en  = 1'b1;
    addr   = 4'h0;
    repeat (6) tick();
    chk("lat_pre", rdata, 32'h0);
    tick();
    chk("lat_post", rdata, 32'h5);
    rd_en = 1'b0;
    rd_chk("edge_rise", 4'h4, 32'h05);
    chk("irq_off", {31'h0, irq}, 32'h0);

    switch = 4'b0000;
    repeat (8) tick();
    rd_chk("edge_both", 4'h4, 32'h55);
    bus_wr(4'h4, 32'h0);
    rd_chk("edge_w0", 4'h4, 32'h55);
    bus_wr(4'h4, 32'hFF);
    rd_chk("edge_clr", 4'h4, 32'h0);
    rd_chk("state_fall", 4'h0, 32'h0);

    // three-cycle glitch is filtered
    switch = 4'b0001;
    repeat (3) tick();
    switch = 4'b0000;
    repeat (10) tick();
    rd_chk("glitch_state", 4'h0, 32'h0);
    rd_chk("glitch_edge", 4'h4, 32'h0);

    // irq follows EDGE & IRQ_EN one edge later
    bus_wr(4'h8, 32'h1);
    rd_chk("ien_rd", 4'h8, 32'h1);
    switch = 4'b0001;
    repeat (6) tick();
    chk("irq_pre", {31'h0, irq}, 32'h0);
    tick();
    chk("irq_set", {31'h0, irq}, 32'h1);
    rd_chk("edge_b0", 4'h4, 32'h01);
    bus_wr(4'h4, 32'h1);
    chk("irq_hold", {31'h0, irq}, 32'h1);
    tick();
    chk("irq_drop", {31'h0, irq}, 32'h0);
    rd_chk("edge_b0_clr", 4'h4, 32'h0);
    switch = 4'b0000;
    repeat (8) tick();
    chk("irq_masked", {31'h0, irq}, 32'h0);
    rd_chk("edge_fall0", 4'h4, 32'h10);
    bus_wr(4'h4, 32'hFF);
    bus_wr(4'h8, 32'h0);

    // W1C on the very edge bit 1 rises: set wins
    switch = 4'b0010;
    repeat (5) tick();
    wr_en = 1'b1;
    addr  = 4'h4;
    wdata = 32'h2;
    tick();
    wr_en = 1'b0;
    rd_chk("set_wins", 4'h4, 32'h02);
    rd_chk("state_b1", 4'h0, 32'h2);

    // unmapped access, rdata hold, IRQ_EN masking
    rd_chk("unmapped", 4'hC, 32'h0);
    rd_chk("state_again", 4'h0, 32'h2);
    tick();
    chk("rv_drop", {31'h0, rvalid}, 32'h0);
    chk("rdata_hold", rdata, 32'h2);
    bus_wr(4'h8, 32'hFFFF_FFFF);
    rd_chk("ien_mask", 4'h8, 32'hFF);
    chk("irq_b1", {31'h0, irq}, 32'h1);
    bus_wr(4'hC, 32'hFF);
    rd_chk("ien_keep", 4'h8, 32'hFF);
    rd_chk("edge_keep", 4'h4, 32'h02);

    // read and write together return pre-write contents
    rd_en = 1'b1;
    wr_en = 1'b1;
    addr  = 4'h4;
    wdata = 32'h2;
    tick();
    rd_en = 1'b0;
    wr_en = 1'b0;
    chk("rw_rv", {31'h0, rvalid}, 32'h1);
    chk("rw_pre", rdata, 32'h2);
    chk("rw_irq_hold", {31'h0, irq}, 32'h1);
    tick();
    chk("rw_irq_drop", {31'h0, irq}, 32'h0);
    rd_chk("rw_post", 4'h4, 32'h0);

    // reset mid-debounce, then full-latency recovery
    switch = 4'b1111;
    rd_en  = 1'b1;
    addr   = 4'h0;
    repeat (3) tick();
    chk("pre_rst_rdata", rdata, 32'h2);
    chk("pre_rst_rv", {31'h0, rvalid}, 32'h1);
    #2;
    reset = 1'b0;
    #1;
    chk("async_rdata", rdata, 32'h0);
    chk("async_rv", {31'h0, rvalid}, 32'h0);
    chk("async_irq", {31'h0, irq}, 32'h0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (6) tick();
    chk("rst_lat_pre", rdata, 32'h0);
    tick();
    chk("rst_lat_post", rdata, 32'hF);
    rd_en = 1'b0;
    rd_chk("rst_edge", 4'h4, 32'h0F);
    rd_chk("rst_ien", 4'h8, 32'h0);
    chk("rst_irq_off", {31'h0, irq}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
